// File: rtl/hcsr04_distance_meter.sv
// HC-SR04 front end: fires the trigger pulse, times the echo and converts the
// echo width to whole centimetres as a saturating 3-digit BCD value.
//
// state         | meaning
// --------------+--------------------------------------------------------
// inicial       | idle, waiting for medir
// preparacao    | clear trigger counter, cycle counter and BCD counter
// envia_trigger | trigger high for TRIGGER_CYCLES cycles
// espera_echo   | waiting for synchronised echo to rise
// medida        | counting echo-high cycles into the BCD counter
// armazenamento | latch BCD counter into the medida register
// final_medida  | one-cycle pronto, then back to idle
module hcsr04_distance_meter #(
   parameter int TRIGGER_CYCLES = 500,
   parameter int CM_CYCLES      = 2941
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        medir_i,
   input  logic        echo_i,
   output logic        trigger_o,
   output logic [11:0] medida_o,
   output logic        pronto_o,
   output logic [2:0]  db_estado_o
);

   localparam int TRIG_W = (TRIGGER_CYCLES > 1) ? $clog2(TRIGGER_CYCLES) : 1;
   localparam int CYC_W  = (CM_CYCLES > 1) ? $clog2(CM_CYCLES) : 1;

   typedef enum logic [2:0] {
      INICIAL       = 3'd0,
      PREPARACAO    = 3'd1,
      ENVIA_TRIGGER = 3'd2,
      ESPERA_ECHO   = 3'd3,
      MEDIDA        = 3'd4,
      ARMAZENAMENTO = 3'd5,
      FINAL_MEDIDA  = 3'd6
   } state_t;

   state_t            state_q, state_d;
   logic              echo_meta_q, echo_s_q;
   logic [TRIG_W-1:0] trig_cnt_q, trig_cnt_d;
   logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
   logic [11:0]       bcd_q, bcd_d;
   logic [11:0]       medida_q, medida_d;
   logic              trig_done;
   logic              count_en;

   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [3:0] u, t, h;
      u = v[3:0];
      t = v[7:4];
      h = v[11:8];
      if (v == 12'h999) begin
         return v;
      end
      if (u == 4'd9) begin
         u = 4'd0;
         if (t == 4'd9) begin
            t = 4'd0;
            h = h + 4'd1;
         end else begin
            t = t + 4'd1;
         end
      end else begin
         u = u + 4'd1;
      end
      return {h, t, u};
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         echo_meta_q <= 1'b0;
         echo_s_q    <= 1'b0;
      end else begin
         echo_meta_q <= echo_i;
         echo_s_q    <= echo_meta_q;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= INICIAL;
      end else begin
         state_q <= state_d;
      end
   end

   assign trig_done = (trig_cnt_q == TRIG_W'(TRIGGER_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         INICIAL:       if (medir_i) state_d = PREPARACAO;
         PREPARACAO:    state_d = ENVIA_TRIGGER;
         ENVIA_TRIGGER: if (trig_done) state_d = ESPERA_ECHO;
         ESPERA_ECHO: begin
            if (medir_i)       state_d = PREPARACAO;
            else if (echo_s_q) state_d = MEDIDA;
         end
         MEDIDA: begin
            if (medir_i)        state_d = PREPARACAO;
            else if (!echo_s_q) state_d = ARMAZENAMENTO;
         end
         ARMAZENAMENTO: state_d = FINAL_MEDIDA;
         FINAL_MEDIDA:  state_d = INICIAL;
         default:       state_d = INICIAL;
      endcase
   end

   always_comb begin
      trigger_o   = (state_q == ENVIA_TRIGGER);
      pronto_o    = (state_q == FINAL_MEDIDA);
      db_estado_o = state_q;
      medida_o    = medida_q;
   end

   // The rising cycle seen in espera_echo is counted too, so N is exact.
   assign count_en = echo_s_q && !medir_i &&
                     ((state_q == ESPERA_ECHO) || (state_q == MEDIDA));

   always_comb begin
      trig_cnt_d = trig_cnt_q;
      cyc_cnt_d  = cyc_cnt_q;
      bcd_d      = bcd_q;
      medida_d   = medida_q;
      case (state_q)
         PREPARACAO: begin
            trig_cnt_d = '0;
            cyc_cnt_d  = '0;
            bcd_d      = '0;
         end
         ENVIA_TRIGGER: trig_cnt_d = trig_cnt_q + TRIG_W'(1);
         ARMAZENAMENTO: medida_d = bcd_q;
         default: ;
      endcase
      if (count_en) begin
         if (cyc_cnt_q == CYC_W'(CM_CYCLES - 1)) begin
            cyc_cnt_d = '0;
            bcd_d     = bcd_inc(bcd_q);
         end else begin
            cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         trig_cnt_q <= '0;
         cyc_cnt_q  <= '0;
         bcd_q      <= '0;
         medida_q   <= '0;
      end else begin
         trig_cnt_q <= trig_cnt_d;
         cyc_cnt_q  <= cyc_cnt_d;
         bcd_q      <= bcd_d;
         medida_q   <= medida_d;
      end
   end

endmodule
